// File: rtl/adc_frame_fifo.sv
// Multi-channel ADC sample buffer: one shared synchronous RAM partitioned into per-channel
// circular FIFOs, with frame-ready detection, overflow auto-flush and underflow flagging.
module adc_frame_fifo #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned FRAME    = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(CHANNELS)-1:0] wr_chan,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  input  logic [$clog2(CHANNELS)-1:0] rd_chan,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid,
  input  logic                        flush,
  output logic                        frame_ready,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned CHW    = $clog2(CHANNELS);
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned AW     = CHW + PW;
  localparam int unsigned NWORDS = CHANNELS * DEPTH;

  logic [WIDTH-1:0]    mem [NWORDS];
  logic [PW-1:0]       wptr_q [CHANNELS];
  logic [PW-1:0]       rptr_q [CHANNELS];
  logic [CW-1:0]       cnt_q  [CHANNELS];

  logic                wr_full_c;
  logic                rd_empty_c;
  logic                ovf_c;
  logic                udf_c;
  logic                clr_c;
  logic                do_wr_c;
  logic                do_rd_c;
  logic                all_frame_c;
  logic [AW-1:0]       wr_addr_c;
  logic [AW-1:0]       rd_addr_c;
  logic [CHANNELS-1:0] wr_hit_c;
  logic [CHANNELS-1:0] rd_hit_c;

  // Decisions use pre-edge counts, so a read of an empty channel is rejected even with a same-cycle write
  always_comb begin
    wr_full_c   = (cnt_q[wr_chan] == CW'(DEPTH));
    rd_empty_c  = (cnt_q[rd_chan] == '0);
    ovf_c       = wr_en & wr_full_c & ~flush;
    clr_c       = flush | ovf_c;
    do_wr_c     = wr_en & ~wr_full_c & ~flush;
    do_rd_c     = rd_en & ~rd_empty_c & ~clr_c;
    udf_c       = rd_en & rd_empty_c & ~clr_c;
    wr_addr_c   = {wr_chan, wptr_q[wr_chan]};
    rd_addr_c   = {rd_chan, rptr_q[rd_chan]};
    wr_hit_c    = '0;
    rd_hit_c    = '0;
    all_frame_c = 1'b1;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      wr_hit_c[c] = do_wr_c && (wr_chan == CHW'(c));
      rd_hit_c[c] = do_rd_c && (rd_chan == CHW'(c));
      if (cnt_q[c] < CW'(FRAME)) all_frame_c = 1'b0;
    end
  end

  // Per-channel pointers and occupancy; flush/overflow clear everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else if (clr_c) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (wr_hit_c[c]) wptr_q[c] <= wptr_q[c] + PW'(1);
        if (rd_hit_c[c]) rptr_q[c] <= rptr_q[c] + PW'(1);
        cnt_q[c] <= cnt_q[c] + CW'(wr_hit_c[c]) - CW'(rd_hit_c[c]);
      end
    end
  end

  // Sample RAM write port; contents are never cleared, occupancy gating hides stale data
  always_ff @(posedge clk) begin
    if (do_wr_c) mem[wr_addr_c] <= wr_data;
  end

  // Registered read port and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      if (do_rd_c) rd_data <= mem[rd_addr_c];
      rd_valid    <= do_rd_c;
      overflow    <= ovf_c;
      underflow   <= udf_c;
      frame_ready <= all_frame_c;
    end
  end

endmodule

// File: tb/tb_adc_frame_fifo.sv
// Directed self-checking bench for adc_frame_fifo: vector table plus multi-cycle sequences.
module tb_adc_frame_fifo;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_chan;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_chan;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        flush;
  logic        frame_ready;
  logic        overflow;
  logic        underflow;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_chan;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_chan;
    logic        flush;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_ovf;
    logic        exp_udf;
  } vec_t;

  vec_t        vt[$];
  logic [15:0] exp_q[$];

  adc_frame_fifo #(.CHANNELS(8), .WIDTH(16), .DEPTH(256), .FRAME(128)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
    .rd_en(rd_en), .rd_chan(rd_chan), .rd_data(rd_data), .rd_valid(rd_valid),
    .flush(flush), .frame_ready(frame_ready), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input logic [2:0] wc, input logic [15:0] wd,
                              input logic re, input logic [2:0] rc, input logic fl,
                              input logic ev, input logic [15:0] ed, input logic eo,
                              input logic eu);
    vec_t v;
    v.wr_en = we; v.wr_chan = wc; v.wr_data = wd;
    v.rd_en = re; v.rd_chan = rc; v.flush = fl;
    v.exp_valid = ev; v.exp_data = ed; v.exp_ovf = eo; v.exp_udf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic [2:0] wc, input logic [15:0] wd,
                       input logic re, input logic [2:0] rc, input logic fl);
    wr_en = we; wr_chan = wc; wr_data = wd;
    rd_en = re; rd_chan = rc; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #12;
    chk("reset rd_data", 32'(rd_data), 32'h0);
    chk("reset rd_valid", 32'(rd_valid), 32'h0);
    chk("reset frame_ready", 32'(frame_ready), 32'h0);
    chk("reset flags", 32'({overflow, underflow}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Ordered read-back, underflow, same-cycle write/read on empty, flush
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(1, 3, 16'(16'h1000 + i), 0, 0, 0, 0, 16'h0000, 0, 0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0, 0, 16'h0, 1, 3, 0, 1, 16'(16'h1000 + i), 0, 0));
    vt.push_back(mk(0, 0, 16'h0,    1, 5, 0, 0, 16'h1004, 0, 1));
    vt.push_back(mk(1, 1, 16'h00AA, 1, 1, 0, 0, 16'h1004, 0, 1));
    vt.push_back(mk(0, 0, 16'h0,    1, 1, 0, 1, 16'h00AA, 0, 0));
    vt.push_back(mk(0, 0, 16'h0,    0, 0, 0, 0, 16'h00AA, 0, 0));
    vt.push_back(mk(1, 2, 16'h0011, 0, 0, 0, 0, 16'h00AA, 0, 0));
    vt.push_back(mk(1, 2, 16'h0022, 0, 0, 0, 0, 16'h00AA, 0, 0));
    vt.push_back(mk(1, 2, 16'h0033, 1, 2, 1, 0, 16'h00AA, 0, 0));
    vt.push_back(mk(0, 0, 16'h0,    1, 2, 0, 0, 16'h00AA, 0, 1));

    foreach (vt[k]) begin
      drive(vt[k].wr_en, vt[k].wr_chan, vt[k].wr_data, vt[k].rd_en, vt[k].rd_chan, vt[k].flush);
      step();
      chk($sformatf("vec%0d rd_valid", k), 32'(rd_valid), 32'(vt[k].exp_valid));
      chk($sformatf("vec%0d rd_data", k), 32'(rd_data), 32'(vt[k].exp_data));
      chk($sformatf("vec%0d overflow", k), 32'(overflow), 32'(vt[k].exp_ovf));
      chk($sformatf("vec%0d underflow", k), 32'(underflow), 32'(vt[k].exp_udf));
    end

    // Frame readiness: 128 per channel except channel 7 one short
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < ((c == 7) ? 127 : 128); i++) begin
        drive(1, 3'(c), 16'(c * 1000 + i + 1), 0, 0, 0);
        step();
      end
    idle(); step(); step();
    chk("frame_ready one short", 32'(frame_ready), 32'h0);
    drive(1, 3'd7, 16'h7777, 0, 0, 0); step();
    idle(); step();
    chk("frame_ready full", 32'(frame_ready), 32'h1);
    drive(0, 0, 16'h0, 1, 3'd0, 0); step();
    chk("frame read data", 32'(rd_data), 32'h1);
    idle(); step();
    chk("frame_ready drop", 32'(frame_ready), 32'h0);
    drive(0, 0, 16'h0, 0, 0, 1); step();
    chk("flush no pulses", 32'({overflow, underflow}), 32'h0);

    // Overflow clears all channels and cancels a same-cycle read
    drive(1, 3'd0, 16'h0C0C, 0, 0, 0); step();
    for (int i = 0; i < 256; i++) begin
      drive(1, 3'd2, 16'(16'h2000 + i), 0, 0, 0);
      step();
    end
    drive(1, 3'd2, 16'hBEEF, 1, 3'd0, 0); step();
    chk("overflow pulse", 32'(overflow), 32'h1);
    chk("overflow read cancelled", 32'(rd_valid), 32'h0);
    chk("overflow no underflow", 32'(underflow), 32'h0);
    idle(); step();
    chk("overflow single cycle", 32'(overflow), 32'h0);
    drive(0, 0, 16'h0, 1, 3'd0, 0); step();
    chk("post-ovf ch0 underflow", 32'({rd_valid, underflow}), 32'h1);
    drive(0, 0, 16'h0, 1, 3'd2, 0); step();
    chk("post-ovf ch2 underflow", 32'({rd_valid, underflow}), 32'h1);
    drive(1, 3'd2, 16'h1234, 0, 0, 0); step();
    drive(0, 0, 16'h0, 1, 3'd2, 0); step();
    chk("post-ovf ch2 valid", 32'(rd_valid), 32'h1);
    chk("post-ovf ch2 data", 32'(rd_data), 32'h1234);

    // Pointer wrap on channel 0 with a steady 150-deep backlog
    for (int i = 0; i < 300; i++) begin
      logic        re;
      logic        pop;
      logic [15:0] ed;
      re  = (i >= 150);
      pop = re && (exp_q.size() > 0);
      ed  = pop ? exp_q.pop_front() : 16'h0;
      drive(1, 3'd0, 16'(16'h4000 + i), re, 3'd0, 0);
      step();
      exp_q.push_back(16'(16'h4000 + i));
      chk($sformatf("wrap%0d rd_valid", i), 32'(rd_valid), 32'(pop));
      if (pop) chk($sformatf("wrap%0d rd_data", i), 32'(rd_data), 32'(ed));
    end
    while (exp_q.size() > 0) begin
      logic [15:0] ed;
      ed = exp_q.pop_front();
      drive(0, 0, 16'h0, 1, 3'd0, 0);
      step();
      chk("drain rd_valid", 32'(rd_valid), 32'h1);
      chk("drain rd_data", 32'(rd_data), 32'(ed));
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd0, 16'(16'h5001 + i), 0, 0, 0);
      step();
    end
    drive(0, 0, 16'h0, 1, 3'd0, 0); step();
    chk("pre-reset data", 32'(rd_data), 32'h5001);
    idle();
    #2 rst = 1'b0;
    #1;
    chk("async reset outputs", 32'({rd_data, rd_valid, frame_ready, overflow, underflow}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    drive(0, 0, 16'h0, 1, 3'd0, 0); step();
    chk("post-reset underflow", 32'({rd_valid, underflow}), 32'h1);
    idle(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_frame_fifo.md
ADC_FRAME_FIFO -- requirements
Module: adc_frame_fifo

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of ADC channels (power of two).
REQ-002 SHALL have parameter WIDTH, default 16, sample width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, samples per channel (power of two).
REQ-004 SHALL have parameter FRAME, default 128, per-channel sample count defining a ready frame (1 <= FRAME <= DEPTH).
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en, input, 1, write strobe for one sample.
REQ-008 SHALL have port wr_chan, input, log2(CHANNELS), channel of the written sample.
REQ-009 SHALL have port wr_data, input, WIDTH, sample value.
REQ-010 SHALL have port rd_en, input, 1, read strobe.
REQ-011 SHALL have port rd_chan, input, log2(CHANNELS), channel to read.
REQ-012 SHALL have port rd_data, output, WIDTH, read sample.
REQ-013 SHALL have port rd_valid, output, 1, rd_data qualifier.
REQ-014 SHALL have port flush, input, 1, synchronous empty-all request.
REQ-015 SHALL have port frame_ready, output, 1, every channel holds >= FRAME samples.
REQ-016 SHALL have port overflow, output, 1, single-cycle pulse on overflow flush.
REQ-017 SHALL have port underflow, output, 1, single-cycle pulse on read of an empty channel.

Function
REQ-018 SHALL store samples in one CHANNELS*DEPTH x WIDTH synchronous RAM, address {chan, ptr}, one write and one read port.
REQ-019 SHALL keep per-channel write pointer, read pointer and count (log2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
REQ-020 SHALL, on wr_en to a non-full channel, store wr_data at that channel's write pointer, then increment pointer and count.
REQ-021 SHALL, on rd_en to a non-empty channel, present that channel's oldest sample on rd_data with rd_valid high exactly one cycle later, then increment read pointer and decrement count.
REQ-022 SHALL, on rd_en to an empty channel, leave pointers unchanged, keep rd_valid low and pulse underflow next cycle; rd_data holds its previous value.
REQ-023 SHALL, on simultaneous write and read to the same non-empty channel, perform both; count unchanged.
REQ-024 SHALL, on simultaneous write and read to the same empty channel, accept the write, reject the read as in REQ-022.
REQ-025 SHALL, on wr_en to a full channel (count == DEPTH), discard that sample, reset all pointers and counts to zero and pulse overflow next cycle; a same-cycle read is cancelled (rd_valid low).
REQ-026 SHALL, on flush high, reset all pointers and counts to zero, ignoring same-cycle wr_en and rd_en; no overflow/underflow pulse.
REQ-027 SHALL drive frame_ready registered: high the cycle after all counts >= FRAME, low the cycle after any count < FRAME.
REQ-028 SHALL give flush priority over overflow, and overflow priority over normal writes/reads.
REQ-029 SHALL NOT read RAM contents written in the same cycle (no write-through requirement; read of just-written empty slot is rejected per REQ-024).

Reset
REQ-030 SHALL, while rst is low, asynchronously force all pointers and counts to 0, rd_data to 0, rd_valid, frame_ready, overflow, underflow to 0.
REQ-031 SHALL NOT require RAM contents to be cleared by reset; stale contents SHALL never be returned.
REQ-032 SHALL resume normal operation the first clk edge after rst deasserts; reset mid-transfer discards all stored samples.

Verification
REQ-033 Write 0x1000+i to channel 3, i=0..4, then 5 reads of channel 3 -> rd_data 0x1000..0x1004 in order, each rd_valid one cycle after rd_en.
REQ-034 Write FRAME=128 samples to channels 0..6 and 127 to channel 7 -> frame_ready low; one more to channel 7 -> frame_ready high next cycle; one read of channel 0 -> low next cycle.
REQ-035 Fill channel 2 to 256 then write 0xBEEF to channel 2 -> overflow pulses one cycle, all counts 0, subsequent read of any channel -> underflow, rd_valid low.
REQ-036 Read empty channel 5 -> underflow pulse, rd_valid low, rd_data unchanged; simultaneous write 0x00AA and read on empty channel 1, then read -> 0x00AA.
REQ-037 Write 10 samples, assert flush with wr_en and rd_en high same cycle -> all empty, no pulses, write not stored.
REQ-038 Write 300 samples across wrap with interleaved reads on channel 0 keeping count <= 200 -> data order preserved across pointer wrap; rst low mid-stream -> all outputs 0 immediately, reads afterwards underflow.
